// File: rtl/div_seq.sv
// Sequential non-restoring radix-2 divider: q = (a << (QBITS-1)) / b, STEPS quotient bits per clock.
// Handshake: in_ready is high only in IDLE; out_valid is high only in DONE; a transfer happens on a rising edge with valid and ready both high.
`timescale 1ns/1ps
module div_seq #(
    parameter int WIDTH = 24,
    parameter int QBITS = 25,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QBITS-1:0] q,
    output logic [WIDTH-1:0] rem,
    output logic             sticky,
    output logic             dz,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int PW   = WIDTH + 2;
    localparam int NCYC = QBITS / STEPS;
    localparam int CW   = $clog2(NCYC + 1);
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    generate
        if ((QBITS % STEPS) != 0) begin : g_bad_steps
            $error("div_seq: QBITS must be a multiple of STEPS");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [PW-1:0]    pr_q, pr_d;
    logic [QBITS-1:0]        qw_q, qw_d;
    logic [WIDTH-1:0]        b_q, b_d;
    logic [QBITS-1:0]        q_q, q_d;
    logic [WIDTH-1:0]        rem_q, rem_d;
    logic                    sticky_q, sticky_d;
    logic                    dz_q, dz_d;
    logic                    ovf_q, ovf_d;

    logic signed [PW-1:0]    b_ext;
    logic signed [PW-1:0]    pr_step;
    logic signed [PW-1:0]    sh;
    logic signed [PW-1:0]    pr_fix;
    logic [STEPS-1:0]        dig;

    assign b_ext = {2'b00, b_q};

    // The very first digit compares a against b directly; later digits work on 2*pr.
    always_comb begin
        pr_step = pr_q;
        sh      = '0;
        dig     = '0;
        for (int s = 0; s < STEPS; s++) begin
            if (cnt_q == '0 && s == 0) sh = pr_step;
            else                       sh = pr_step <<< 1;
            if (pr_step[PW-1]) pr_step = sh + b_ext;
            else               pr_step = sh - b_ext;
            dig[STEPS-1-s] = ~pr_step[PW-1];
        end
    end

    assign pr_fix = pr_q[PW-1] ? (pr_q + b_ext) : pr_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pr_d     = pr_q;
        qw_d     = qw_q;
        b_d      = b_q;
        q_d      = q_q;
        rem_d    = rem_q;
        sticky_d = sticky_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    b_d   = b;
                    cnt_d = '0;
                    qw_d  = '0;
                    pr_d  = {2'b00, a};
                    if (b == '0) begin
                        state_d  = DONE;
                        dz_d     = 1'b1;
                        ovf_d    = 1'b0;
                        q_d      = '1;
                        rem_d    = '0;
                        sticky_d = 1'b0;
                    end else if ({1'b0, a} >= {b, 1'b0}) begin
                        state_d  = DONE;
                        dz_d     = 1'b0;
                        ovf_d    = 1'b1;
                        q_d      = '1;
                        rem_d    = '0;
                        sticky_d = 1'b0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                pr_d  = pr_step;
                qw_d  = (qw_q << STEPS) | QBITS'(dig);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                pr_d     = pr_fix;
                q_d      = qw_q;
                rem_d    = pr_fix[WIDTH-1:0];
                sticky_d = |pr_fix[WIDTH-1:0];
                dz_d     = 1'b0;
                ovf_d    = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pr_q     <= '0;
            qw_q     <= '0;
            b_q      <= '0;
            q_q      <= '0;
            rem_q    <= '0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pr_q     <= pr_d;
            qw_q     <= qw_d;
            b_q      <= b_d;
            q_q      <= q_d;
            rem_q    <= rem_d;
            sticky_q <= sticky_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = q_q;
    assign rem       = rem_q;
    assign sticky    = sticky_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: a STEPS=1 instance for directed cases and a STEPS=5 instance for random pairs.
// Expected results come from a 64-bit arithmetic model and are queued at issue, popped at result.
`timescale 1ns/1ps
module tb_div_seq;

    localparam int W  = 24;
    localparam int QB = 25;
    localparam int EW = 3 + W + QB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // STEPS=1 instance
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a, b, rem;
    logic [QB-1:0] q;
    logic          sticky, dz, ovf;
    logic [1:0]    dbg_state;

    // STEPS=5 instance
    logic          in_valid5, in_ready5, out_valid5, out_ready5;
    logic [W-1:0]  a5, b5, rem5;
    logic [QB-1:0] q5;
    logic          sticky5, dz5, ovf5;
    logic [1:0]    dbg_state5;

    div_seq #(.WIDTH(W), .QBITS(QB), .STEPS(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .rem(rem), .sticky(sticky),
        .dz(dz), .ovf(ovf), .dbg_state(dbg_state)
    );

    div_seq #(.WIDTH(W), .QBITS(QB), .STEPS(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .a(a5), .b(b5),
        .out_valid(out_valid5), .out_ready(out_ready5), .q(q5), .rem(rem5), .sticky(sticky5),
        .dz(dz5), .ovf(ovf5), .dbg_state(dbg_state5)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp5_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, expv);
        end
    endtask

    // Packed as {dz, ovf, sticky, rem, q}
    function automatic logic [EW-1:0] ref_model(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [63:0] n, qq, rr;
        if (bv == '0) return {3'b100, {W{1'b0}}, {QB{1'b1}}};
        if ({1'b0, av} >= {bv, 1'b0}) return {3'b010, {W{1'b0}}, {QB{1'b1}}};
        n  = 64'(av) << (QB - 1);
        qq = n / 64'(bv);
        rr = n % 64'(bv);
        return {1'b0, 1'b0, (rr != 0), rr[W-1:0], qq[QB-1:0]};
    endfunction

    // ---------------- driver (STEPS=1 instance) ----------------
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int exp_lat,
                          input int hold, input bit pulse);
        int lat;
        logic [EW-1:0] got, expv, snap;
        lat = 0;
        while (!in_ready && lat < 100) begin @(posedge clk); #1; lat++; end
        check_eq("ready_before_issue", in_ready, 1'b1);
        in_valid = 1'b1; a = av; b = bv;
        exp_q.push_back(ref_model(av, bv));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        lat = 1;
        if (pulse) begin
            in_valid = 1'b1; b = '0; out_ready = 1'b1;
            repeat (5) begin
                check_eq("busy_in_ready", {in_ready, out_valid}, 2'b00);
                @(posedge clk); #1; lat++;
            end
            in_valid = 1'b0; out_ready = 1'b0;
        end
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check_eq("latency", lat, exp_lat);
        got  = {dz, ovf, sticky, rem, q};
        expv = exp_q.pop_front();
        check_eq("q", got[QB-1:0], expv[QB-1:0]);
        check_eq("rem", got[QB+W-1:QB], expv[QB+W-1:QB]);
        check_eq("flags_dz_ovf_sticky", got[EW-1:EW-3], expv[EW-1:EW-3]);
        snap = got;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_outputs", {dz, ovf, sticky, rem, q}, snap);
            check_eq("hold_valid_ready", {out_valid, in_ready}, 2'b10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("release_valid_ready", {out_valid, in_ready}, 2'b01);
        check_eq("idle_keeps_outputs", {dz, ovf, sticky, rem, q}, snap);
    endtask

    task automatic check_reset_state();
        check_eq("rst_ready_valid", {in_ready, out_valid, in_ready5, out_valid5}, 4'b1010);
        check_eq("rst_q", q, 0);
        check_eq("rst_rem", rem, 0);
        check_eq("rst_flags", {dz, ovf, sticky, dz5, ovf5, sticky5}, 0);
        check_eq("rst_state", {dbg_state, dbg_state5}, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] av, bv;
    int lat5;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid5 = 1'b0; out_ready5 = 1'b0; a5 = '0; b5 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;

        // First edge after reset release accepts; exact division
        run_op(24'h800000, 24'h800000, 27, 0, 0);
        check_eq("q_1_0", q, 25'h1000000);
        run_op(24'h800000, 24'hC00000, 27, 0, 0);
        check_eq("q_2_3", q, 25'h0AAAAAA);
        check_eq("rem_2_3", {sticky, rem}, {1'b1, 24'h800000});
        run_op(24'hC00000, 24'h800000, 27, 0, 0);
        check_eq("q_3_2", {sticky, q}, {1'b0, 25'h1800000});

        // Divide by zero and overflow take the short path
        run_op(24'h123456, 24'h000000, 1, 0, 0);
        check_eq("dz_case", {dz, ovf, q}, {2'b10, 25'h1FFFFFF});
        run_op(24'h800000, 24'h400000, 1, 0, 0);
        check_eq("ovf_case", {dz, ovf, q}, {2'b01, 25'h1FFFFFF});
        run_op(24'h7FFFFF, 24'h400000, 27, 0, 0);
        check_eq("flags_cleared", {dz, ovf}, 2'b00);
        run_op(24'h000000, 24'h000005, 27, 0, 0);

        // Back-pressure and inputs toggling while busy
        run_op(24'hABCDEF, 24'h9A0001, 27, 10, 0);
        run_op(24'h812345, 24'hF00000, 27, 0, 1);

        // Reset in the middle of a division, then a fresh pair
        @(negedge clk);
        in_valid = 1'b1; a = 24'hC00000; b = 24'h800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_state();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(24'h900000, 24'hA00000, 27, 0, 0);

        for (int i = 0; i < 4; i++) begin
            bv = W'($urandom_range(24'hFFFFFF, 1));
            av = W'($urandom_range((bv > 24'h7FFFFF) ? 24'hFFFFFF : 32'(2 * bv - 1), 0));
            run_op(av, bv, 27, 0, 0);
        end

        // STEPS=5: corner pairs then random normalized pairs, consumer always ready
        out_ready5 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (i == 0)      begin av = 24'h800000; bv = 24'h800000; end
            else if (i == 1) begin av = 24'hFFFFFF; bv = 24'h800000; end
            else if (i == 2) begin av = 24'h800000; bv = 24'hFFFFFF; end
            else begin
                av = W'($urandom_range(24'hFFFFFF, 24'h800000));
                bv = W'($urandom_range(24'hFFFFFF, 24'h800000));
            end
            check_eq("ready5", in_ready5, 1'b1);
            in_valid5 = 1'b1; a5 = av; b5 = bv;
            exp5_q.push_back(ref_model(av, bv));
            @(posedge clk); #1;
            in_valid5 = 1'b0;
            lat5 = 1;
            while (!out_valid5 && lat5 < 50) begin @(posedge clk); #1; lat5++; end
            check_eq("latency5", lat5, 7);
            check_eq("result5", {dz5, ovf5, sticky5, rem5, q5}, exp5_q.pop_front());
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
